// File: rtl/four_bit_unsigned_mul.sv
// Registered 4x4 unsigned multiplier: an AND partial-product array reduced by three
// ripple-carry adder rows, with the 8-bit product captured in an output register.

module four_bit_unsigned_mul_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module four_bit_unsigned_mul_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module four_bit_unsigned_mul (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] product
);
    logic [3:0][3:0] pp;     // pp[i][j] = A[j] & B[i]
    logic [3:1][3:0] row_up; // addend from the previous row: {carry-out, sum[3:1]}
    logic [3:1][3:0] row_s;
    logic [3:1][3:0] row_c;
    logic [7:0]      product_d;
    logic [7:0]      product_q;

    always_comb begin
        pp = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = A[j] & B[i];
            end
        end
    end

    assign row_up[1] = {1'b0, pp[0][3:1]};

    for (genvar k = 1; k < 4; k++) begin : g_row
        if (k > 1) begin : g_up
            assign row_up[k] = {row_c[k-1][3], row_s[k-1][3:1]};
        end

        four_bit_unsigned_mul_ha u_ha (
            .a_i (pp[k][0]),
            .b_i (row_up[k][0]),
            .s_o (row_s[k][0]),
            .c_o (row_c[k][0])
        );

        for (genvar j = 1; j < 4; j++) begin : g_bit
            four_bit_unsigned_mul_fa u_fa (
                .a_i (pp[k][j]),
                .b_i (row_up[k][j]),
                .c_i (row_c[k][j-1]),
                .s_o (row_s[k][j]),
                .c_o (row_c[k][j])
            );
        end
    end

    // Each row retires one low bit; row 3 supplies the top five bits.
    assign product_d = {row_c[3][3], row_s[3], row_s[2][0], row_s[1][0], pp[0][0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= 8'h00;
        end else begin
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_four_bit_unsigned_mul.sv
// Self-checking bench for four_bit_unsigned_mul: directed vector table, reset and
// hold sequences, an exhaustive sweep and random traffic against an arithmetic model.

module tb_four_bit_unsigned_mul;
    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] product;

    int total;
    int bad;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    four_bit_unsigned_mul dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    // Drive operands away from the edge, clock once, sample just after the edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic r);
        @(negedge clk);
        A   = a;
        B   = b;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        A     = 4'd0;
        B     = 4'd0;
        rst   = 1'b1;

        vecs[0]  = '{4'd0,  4'd0,  8'h00};
        vecs[1]  = '{4'd15, 4'd15, 8'hE1};
        vecs[2]  = '{4'd0,  4'd15, 8'h00};
        vecs[3]  = '{4'd15, 4'd0,  8'h00};
        vecs[4]  = '{4'd1,  4'd10, 8'h0A};
        vecs[5]  = '{4'd15, 4'd1,  8'h0F};
        vecs[6]  = '{4'd3,  4'd4,  8'h0C};
        vecs[7]  = '{4'd12, 4'd6,  8'h48};
        vecs[8]  = '{4'd12, 4'd11, 8'h84};
        vecs[9]  = '{4'd14, 4'd12, 8'hA8};
        vecs[10] = '{4'd9,  4'd7,  8'h3F};
        vecs[11] = '{4'd5,  4'd13, 8'h41};

        // Reset held for two edges with maximal operands.
        step(4'd15, 4'd15, 1'b1);
        check("reset_edge1", product, 8'h00);
        step(4'd15, 4'd15, 1'b1);
        check("reset_edge2", product, 8'h00);
        step(4'd15, 4'd15, 1'b0);
        check("reset_release", product, 8'hE1);

        // Back-to-back directed table, one new pair per cycle.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("vec%0d_%0dx%0d", i, vecs[i].a, vecs[i].b), product, vecs[i].exp);
        end

        // Mid-stream reset pulse: one zero cycle, then results resume.
        step(4'd12, 4'd11, 1'b0);
        check("pre_pulse", product, 8'h84);
        step(4'd14, 4'd12, 1'b1);
        check("pulse_zero", product, 8'h00);
        step(4'd3, 4'd4, 1'b0);
        check("post_pulse", product, 8'h0C);

        // Operand changes between edges must not reach the output early.
        step(4'd15, 4'd15, 1'b0);
        #2;
        A = 4'd2;
        B = 4'd3;
        @(negedge clk);
        check("hold_between_edges", product, 8'hE1);
        @(posedge clk);
        #1;
        check("after_hold_edge", product, 8'h06);

        // Exhaustive sweep with one-cycle latency.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(4'(a), 4'(b), 1'b0);
                check($sformatf("exh_%0dx%0d", a, b), product, ref_mul(4'(a), 4'(b)));
            end
        end

        // Random traffic with occasional reset; the model tracks the register.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rr;
            logic [7:0] exp;
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rr  = ($urandom_range(0, 19) == 0);
            exp = rr ? 8'h00 : ref_mul(ra, rb);
            step(ra, rb, rr);
            check($sformatf("rand%0d_%0dx%0d_r%0d", n, ra, rb, rr), product, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
